tb_mem_arb_sram: RTL and testbench
==================================

Name: tb_mem_arb_sram

Overview:
- Multi-port, byte-enabled SRAM memory model for core-level testbenches.
- Replaces a single-master memory behind a protocol bridge.
- NumPorts request/grant/rvalid masters, for example instruction fetch, data, and an external loader, share one word-addressed array through a round-robin arbiter.
- Read data returns after a parametrised latency; one access is performed per cycle.

Parameters:
- NumPorts, 2, number of requesting ports (1..8)
- DataWidth, 64, word width in bits (power of two, >= 8)
- AddrWidth, 64, byte address width per port
- NumWords, 2**16, array depth in words (power of two)
- ReadLatency, 1, cycles from grant to rvalid (1..8)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req_i  in  NumPorts  per-port request, held until granted
- we_i  in  NumPorts  per-port write enable
- addr_i  in  NumPorts x AddrWidth  per-port byte address
- be_i  in  NumPorts x DataWidth/8  per-port byte enables
- wdata_i  in  NumPorts x DataWidth  per-port write data
- gnt_o  out  NumPorts  one-hot grant, combinational from req_i and arbiter state
- rvalid_o  out  NumPorts  response valid, one cycle per granted access
- rdata_o  out  NumPorts x DataWidth  read data, valid only with rvalid_o

Interface:
- One clock; reset is asynchronous and active-high.
- clk_i is the clock; rst_i is the reset.

Behaviour:
- Reset values:
  - gnt_o=0 while rst_i is asserted.
  - rvalid_o=0, rdata_o=0.
  - Round-robin pointer=0.
  - Response pipeline cleared.
  - Array contents are not reset.
- Word index: addr_i[p][$clog2(NumWords)-1+Off : Off], where Off=$clog2(DataWidth/8).
  - Upper address bits are ignored, so addresses alias modulo NumWords*DataWidth/8.
  - Low Off bits are ignored.
- Arbitration:
  - At most one gnt_o bit is set per cycle.
  - The first requesting port at or after the pointer (wrapping) wins.
  - On a grant to port p, the pointer becomes (p+1) mod NumPorts.
  - With no requests, the pointer holds.
  - A handshake completes on the cycle where req_i[p] and gnt_o[p] are both high.
- Write handshake:
  - Byte k of the word is updated at the clock edge iff be_i[p][k]=1.
  - rvalid_o[p] pulses ReadLatency cycles later with rdata_o[p]=0.
- Read handshake:
  - The word is sampled at the grant edge.
  - rvalid_o[p] rises exactly ReadLatency cycles after the grant cycle, with that data.
  - be_i is ignored for reads.
- Ordering:
  - An access granted at cycle t observes all writes granted at cycles < t.
  - Responses are returned in grant order, and each returns to the port that was granted.
- Throughput: one grant per cycle sustained. The response pipeline holds ReadLatency entries (valid, port id, data), with no backpressure.
- Simultaneous events: a rvalid for an old access and a gnt for a new access on the same port in the same cycle is legal.
- Reset mid-operation: in-flight responses are discarded and no rvalid is produced for them. Partially completed writes are either fully applied or not applied.
- NumPorts=1: the arbiter degenerates to gnt_o=req_i.

Optional Feature:
- Macro: TB_MEM_RANDOM_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset value 16'hACE1) advances every cycle.
  - All grants are suppressed in any cycle where lfsr[1:0]==2'b00.
  - The pointer holds during a stalled cycle.
  - Latency after a grant is unchanged.
- When undefined: no LFSR is present, and a grant is issued in every cycle with any request.

Decomposition:
- Package tb_mem_pkg holds:
  - resp_entry_t {valid, port id [$clog2(NumPorts)], data}.
  - localparam LfsrSeed=16'hACE1.
  - A function to extract the word index.
- Sub-module tb_mem_rr_arb: round-robin arbiter with pointer state, NumPorts parameter, and a stall input.
- The array and response pipeline live in the top level.

Test Plan:
- Single-port write then read:
  - Port0 writes addr 0x80, be=8'hFF, data 64'hDEADBEEF_CAFEF00D; then reads 0x80.
  - Expected: read rvalid at grant+ReadLatency with the same data.
- Byte enables:
  - Port0 writes 64'h0 with be=8'hFF to addr 0x10, then 64'h1122334455667788 with be=8'h0F.
  - Expected: readback 64'h0000000055667788.
- Fairness:
  - Both ports hold req for 6 cycles (stall macro undefined).
  - Expected: grants alternate p0,p1,p0,p1,p0,p1; each port receives 3 rvalids, in order.
- Latency sweep:
  - ReadLatency=3, back-to-back reads of 4 addresses.
  - Expected: rvalid on 4 consecutive cycles starting 3 cycles after the first grant.
- Aliasing:
  - NumWords=16, write addr 0x0 with 64'hA5.
  - Expected: read of addr 0x80 returns 64'hA5.
- Reset mid-flight:
  - ReadLatency=4, grant a read, assert rst_i two cycles later for one cycle.
  - Expected: no rvalid appears; the next grant after reset goes to port0.

Source files
------------

// File: rtl/tb_mem_pkg.sv
// Shared types and helpers for the multi-port testbench SRAM model.
package tb_mem_pkg;

   localparam logic [15:0] LfsrSeed   = 16'hACE1;
   localparam int          MaxPortIdW = 3;    // up to 8 ports
   localparam int          MaxDataW   = 512;  // widest supported word

   // One slot of the read-response pipeline; data bits above DataWidth stay zero.
   typedef struct packed {
      logic                  valid;
      logic [MaxPortIdW-1:0] port;
      logic [MaxDataW-1:0]   data;
   } resp_entry_t;

   // Byte address -> word index: drop the in-word offset, wrap modulo the array depth.
   function automatic logic [31:0] word_index(input logic [63:0] addr,
                                              input int unsigned off,
                                              input int unsigned idx_w);
      return 32'(addr >> off) & ((32'd1 << idx_w) - 32'd1);
   endfunction

endpackage

// File: rtl/tb_mem_arb_sram_rr_arb.sv
// Round-robin arbiter: the first requester at or after the pointer wins, the pointer
// then moves past the winner. A stall or reset suppresses every grant.
module tb_mem_rr_arb #(
   parameter int NumPorts = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NumPorts-1:0] req_i,
   input  logic                stall_i,
   output logic [NumPorts-1:0] gnt_o
);

   localparam int PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [PtrW-1:0] cand;

   // Walk from the farthest candidate back to the pointer so the nearest requester wins.
   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      cand  = '0;
      if (!rst_i && !stall_i) begin
         for (int i = NumPorts - 1; i >= 0; i--) begin
            cand = PtrW'((int'(ptr_q) + i) % NumPorts);
            if (req_i[cand]) begin
               gnt_o       = '0;
               gnt_o[cand] = 1'b1;
               ptr_d       = PtrW'((int'(ptr_q) + i + 1) % NumPorts);
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/tb_mem_arb_sram.sv
// Multi-port byte-enabled SRAM behind a round-robin arbiter with fixed read latency.
// Optional TB_MEM_RANDOM_STALL_EN: LFSR-driven random grant suppression.
module tb_mem_arb_sram
   import tb_mem_pkg::*;
#(
   parameter int NumPorts    = 2,
   parameter int DataWidth   = 64,
   parameter int AddrWidth   = 64,
   parameter int NumWords    = 2**16,
   parameter int ReadLatency = 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [NumPorts-1:0]                  req_i,
   input  logic [NumPorts-1:0]                  we_i,
   input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
   input  logic [NumPorts-1:0][DataWidth/8-1:0] be_i,
   input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
   output logic [NumPorts-1:0]                  gnt_o,
   output logic [NumPorts-1:0]                  rvalid_o,
   output logic [NumPorts-1:0][DataWidth-1:0]   rdata_o
);

   localparam int NumBytes = DataWidth / 8;
   localparam int Off      = $clog2(NumBytes);
   localparam int IdxW     = $clog2(NumWords);
   localparam int SelW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;

   logic stall;

`ifdef TB_MEM_RANDOM_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR, taps 16,14,13,11, shifting right.
   assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
   assign stall  = (lfsr_q[1:0] == 2'b00);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) lfsr_q <= LfsrSeed;
      else       lfsr_q <= lfsr_d;
   end
`else
   assign stall = 1'b0;
`endif

   tb_mem_rr_arb #(.NumPorts(NumPorts)) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (req_i),
      .stall_i (stall),
      .gnt_o   (gnt_o)
   );

   // Grant is one-hot and only on a requesting port, so any grant is a handshake.
   logic                 hs;
   logic [SelW-1:0]      sel_id;
   logic                 sel_we;
   logic [AddrWidth-1:0] sel_addr;
   logic [NumBytes-1:0]  sel_be;
   logic [DataWidth-1:0] sel_wdata;
   logic [IdxW-1:0]      idx;

   assign hs = |gnt_o;

   always_comb begin
      sel_id    = '0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_be    = '0;
      sel_wdata = '0;
      for (int p = 0; p < NumPorts; p++) begin
         if (gnt_o[p]) begin
            sel_id    = SelW'(p);
            sel_we    = we_i[p];
            sel_addr  = addr_i[p];
            sel_be    = be_i[p];
            sel_wdata = wdata_i[p];
         end
      end
   end

   assign idx = IdxW'(word_index(64'(sel_addr), Off, IdxW));

   logic [DataWidth-1:0] mem_q [NumWords];

   always_ff @(posedge clk_i) begin
      if (hs && sel_we) begin
         for (int k = 0; k < NumBytes; k++) begin
            if (sel_be[k]) mem_q[idx][8*k +: 8] <= sel_wdata[8*k +: 8];
         end
      end
   end

   // Read data is captured at the grant edge; writes answer with zero data.
   resp_entry_t pipe_in;
   resp_entry_t pipe_q [ReadLatency];
   resp_entry_t head;

   always_comb begin
      pipe_in       = '0;
      pipe_in.valid = hs;
      pipe_in.port  = MaxPortIdW'(sel_id);
      pipe_in.data  = (hs && !sel_we) ? MaxDataW'(mem_q[idx]) : '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < ReadLatency; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= pipe_in;
         for (int i = 1; i < ReadLatency; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign head = pipe_q[ReadLatency-1];

   for (genvar p = 0; p < NumPorts; p++) begin : g_resp
      assign rvalid_o[p] = head.valid && (head.port == MaxPortIdW'(p));
      assign rdata_o[p]  = rvalid_o[p] ? DataWidth'(head.data) : '0;
   end

endmodule

// File: tb/tb_tb_mem_arb_sram.sv
// Scoreboard bench for tb_mem_arb_sram: 2 ports, 16-word array, read latency 3.
module tb_tb_mem_arb_sram;

   localparam int NP = 2;
   localparam int DW = 64;
   localparam int AW = 64;
   localparam int NW = 16;
   localparam int RL = 3;

   logic                    clk_i, rst_i;
   logic [NP-1:0]           req_i, we_i, gnt_o, rvalid_o;
   logic [NP-1:0][AW-1:0]   addr_i;
   logic [NP-1:0][DW/8-1:0] be_i;
   logic [NP-1:0][DW-1:0]   wdata_i, rdata_o;

   tb_mem_arb_sram #(
      .NumPorts(NP), .DataWidth(DW), .AddrWidth(AW), .NumWords(NW), .ReadLatency(RL)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      int          port;
      logic [63:0] data;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad   = 0;
   logic [63:0] mdl_mem [NW];
   int          mptr = 0;
   logic [NP-1:0] last_gnt, last_exp;
   bit          ovr_en = 0;
   logic [63:0] ovr_d  = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   function automatic int widx(input logic [63:0] a);
      return int'((a >> 3) % NW);
   endfunction

   // One bus cycle: drive, let gnt settle, check against the round-robin rule, update model.
   task automatic step(input logic [1:0] rq, input logic [1:0] w,
                       input logic [63:0] a0, input logic [63:0] a1,
                       input logic [7:0] b0, input logic [7:0] b1,
                       input logic [63:0] d0, input logic [63:0] d1);
      int          win;
      int          wi;
      logic [1:0]  exp_g;
      exp_t        e;
      @(negedge clk_i);
      req_i = rq; we_i = w;
      addr_i[0] = a0; addr_i[1] = a1;
      be_i[0] = b0; be_i[1] = b1;
      wdata_i[0] = d0; wdata_i[1] = d1;
      #1;
      win = -1;
      exp_g = '0;
      if (!rst_i)
         for (int i = 0; i < NP; i++)
            if (win < 0 && rq[(mptr + i) % NP]) win = (mptr + i) % NP;
      if (win >= 0) exp_g[win] = 1'b1;
      total++;
      if (gnt_o !== exp_g) begin
         bad++;
         $display("FAIL gnt cyc=%0d got=%b want=%b", cyc, gnt_o, exp_g);
      end
      last_gnt = gnt_o;
      last_exp = exp_g;
      if (win >= 0) begin
         mptr   = (win + 1) % NP;
         wi     = widx(addr_i[win]);
         e.port = win;
         e.due  = cyc + RL;
         if (w[win]) begin
            for (int k = 0; k < 8; k++)
               if (be_i[win][k]) mdl_mem[wi][8*k +: 8] = wdata_i[win][8*k +: 8];
            e.data = '0;
         end else begin
            e.data = ovr_en ? ovr_d : mdl_mem[wi];
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
   endtask

   // Monitor: every rvalid must match the oldest outstanding expectation, on time.
   always @(negedge clk_i) begin
      if (rvalid_o !== '0) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_rvalid cyc=%0d rvalid=%b", cyc, rvalid_o);
         end else begin
            mon_e = exp_q.pop_front();
            if (rvalid_o !== (2'b01 << mon_e.port) || rdata_o[mon_e.port] !== mon_e.data ||
                cyc != mon_e.due) begin
               bad++;
               $display("FAIL resp cyc=%0d rvalid=%b data=%h want port=%0d data=%h due=%0d",
                        cyc, rvalid_o, rdata_o[mon_e.port], mon_e.port, mon_e.data, mon_e.due);
            end
         end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         mon_e = exp_q.pop_front();
         total++;
         bad++;
         $display("FAIL missing_rvalid cyc=%0d want port=%0d due=%0d", cyc, mon_e.port, mon_e.due);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d", total);
      $fatal(1, "watchdog");
   end

   logic [1:0]  pend, rw;
   logic [63:0] ra [2];
   logic [63:0] rd [2];
   logic [7:0]  rb [2];

   initial begin
      rst_i = 1'b1; req_i = '0; we_i = '0; addr_i = '0; be_i = '0; wdata_i = '0;
      repeat (3) @(negedge clk_i);
      req_i = 2'b11;
      #1;
      chk("rst_gnt",    128'(gnt_o),    128'(0));
      chk("rst_rvalid", 128'(rvalid_o), 128'(0));
      chk("rst_rdata",  128'(rdata_o),  128'(0));
      @(negedge clk_i);
      rst_i = 1'b0;
      req_i = '0;

      // Fill every word from port 1 so later reads are all defined.
      for (int w = 0; w < NW; w++)
         step(2'b10, 2'b10, '0, 64'(w * 8), '0, 8'hFF, '0, {$urandom, $urandom});

      step(2'b01, 2'b01, 64'h80, '0, 8'hFF, '0, 64'hDEADBEEF_CAFEF00D, '0);
      ovr_en = 1; ovr_d = 64'hDEADBEEF_CAFEF00D;
      step(2'b01, 2'b00, 64'h80, '0, 8'hFF, '0, '0, '0);

      step(2'b01, 2'b01, 64'h10, '0, 8'hFF, '0, 64'h0, '0);
      step(2'b01, 2'b01, 64'h10, '0, 8'h0F, '0, 64'h1122334455667788, '0);
      ovr_d = 64'h0000000055667788;
      step(2'b01, 2'b00, 64'h10, '0, 8'h00, '0, '0, '0);

      step(2'b01, 2'b01, 64'h0, '0, 8'hFF, '0, 64'hA5, '0);
      ovr_d = 64'hA5;
      step(2'b01, 2'b00, 64'h80, '0, 8'hFF, '0, '0, '0);
      ovr_en = 0;

      // Back-to-back reads: responses on consecutive cycles RL after each grant.
      step(2'b01, 2'b00, 64'h00, '0, '0, '0, '0, '0);
      step(2'b01, 2'b00, 64'h10, '0, '0, '0, '0, '0);
      step(2'b01, 2'b00, 64'h18, '0, '0, '0, '0, '0);
      step(2'b01, 2'b00, 64'h27, '0, '0, '0, '0, '0);
      idle(RL + 2);
      chk("drain1", 128'(exp_q.size()), 128'(0));

      // Reset two cycles after a read grant: its response must never appear.
      step(2'b01, 2'b00, 64'h30, '0, '0, '0, '0, '0);
      idle(1);
      @(negedge clk_i);
      exp_q.delete();
      rst_i = 1'b1; req_i = '0; mptr = 0;
      #1;
      chk("midrst_rvalid", 128'(rvalid_o), 128'(0));
      @(negedge clk_i);
      rst_i = 1'b0;
      idle(RL + 1);

      // Fairness: both ports held, grants alternate starting at port 0.
      for (int i = 0; i < 6; i++) begin
         step(2'b11, 2'b00, 64'h20, 64'h28, '0, '0, '0, '0);
         chk(i == 0 ? "post_rst_gnt" : "fair_gnt", 128'(last_gnt),
             128'((i % 2 == 0) ? 2'b01 : 2'b10));
      end
      idle(RL + 2);
      chk("drain2", 128'(exp_q.size()), 128'(0));

      // Random traffic; each port holds its request until the model grants it.
      pend = '0; rw = '0;
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < NP; p++) begin
            if (!pend[p] && $urandom_range(0, 3) != 0) begin
               pend[p] = 1'b1;
               rw[p]   = 1'($urandom_range(0, 1));
               ra[p]   = {$urandom, $urandom};
               rb[p]   = 8'($urandom);
               rd[p]   = {$urandom, $urandom};
            end
         end
         step(pend, rw, ra[0], ra[1], rb[0], rb[1], rd[0], rd[1]);
         pend = pend & ~last_exp;
      end
      idle(RL + 2);
      chk("drain3", 128'(exp_q.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
